pl_reset_seq: RTL
=================

# pl_reset_seq

Staged PL reset sequencer between the CIPS PL clock/reset outputs and the fabric. Synchronises the clock wizard `dcm_locked` and an auxiliary reset request, holds all PL resets for a programmable time once lock is stable, and then releases the interconnect reset before the peripheral resets. It also exports a state code and a saturating run-cycle counter so simulation monitors and debug logic can observe reset progress without probing inside CIPS.

## Interface
- `RST_HOLD_CYCLES`, 16: number of cycles all resets stay asserted after lock is qualified; must be ≥1.
- `SEQ_GAP_CYCLES`, 4: number of cycles between interconnect release and peripheral release; must be ≥1.
- `LOCK_TIMEOUT_CYCLES`, 1024: watchdog limit. Used only when `PL_RESET_SEQ_LOCK_WDOG_EN` is defined.
- `pl_clk0` in 1: the single clock, CIPS pl_clk0.
- `pl_rst` in 1: synchronous, active-high reset (inverted pl_resetn).
- `dcm_locked` in 1: clock wizard lock. Asynchronous; synchronised internally.
- `aux_reset_in` in 1: active-high external reset request. Asynchronous; synchronised internally.
- `interconnect_aresetn` out 1: active-low interconnect reset.
- `peripheral_aresetn` out 1: active-low peripheral reset.
- `peripheral_reset` out 1: active-high peripheral reset; always equals `~peripheral_aresetn`.
- `rst_state` out 3: current state code.
- `run_cycles` out 32: cycles spent in RUN; saturating.
- `lock_timeout` out 1: sticky watchdog flag; tied 0 when the watchdog is compiled out.

## Operation
- `dcm_locked` and `aux_reset_in` each pass through a 2-FF synchroniser, giving `locked_s` and `aux_s`. Both synchroniser stages clear to 0 on `pl_rst`.
- State codes: RESET=0, WAIT_LOCK=1, HOLD=2, REL_IC=3, RUN=4.
- Transition priority, highest first: `pl_rst` → RESET; then abort; then count.
- RESET → WAIT_LOCK on the first edge where `pl_rst`=0.
- WAIT_LOCK → HOLD on an edge where `locked_s`=1 and `aux_s`=0. The phase counter loads 0.
- HOLD: the phase counter increments each cycle. HOLD → REL_IC on the edge where the counter equals `RST_HOLD_CYCLES`-1; the counter reloads 0.
- REL_IC: the phase counter increments each cycle. REL_IC → RUN on the edge where the counter equals `SEQ_GAP_CYCLES`-1.
- Abort: in HOLD, REL_IC or RUN, if `locked_s`=0 or `aux_s`=1 the next state is WAIT_LOCK. All resets re-assert on that same edge.
- Output values per state:
  - RESET, WAIT_LOCK, HOLD: `interconnect_aresetn`=0, `peripheral_aresetn`=0.
  - REL_IC: `interconnect_aresetn`=1, `peripheral_aresetn`=0.
  - RUN: `interconnect_aresetn`=1, `peripheral_aresetn`=1.
- `run_cycles`:
  - Increments each cycle while in RUN.
  - Saturates at 0xFFFF_FFFF.
  - Clears to 0 on any edge whose next state is not RUN.
- Phase counter width is `$clog2(max(RST_HOLD_CYCLES,SEQ_GAP_CYCLES))+1`; it never wraps.

## Timing
- All outputs are registered and change on the same edge as the state register; there is no combinational path from inputs to outputs.
- Values while `pl_rst`=1:
  - `rst_state`=0
  - `interconnect_aresetn`=0, `peripheral_aresetn`=0, `peripheral_reset`=1
  - `run_cycles`=0, `lock_timeout`=0
- Input-to-state latency: a change on `dcm_locked` or `aux_reset_in` reaches the FSM 2 edges later and changes the state on the 3rd edge.
- Minimum duration in HOLD is exactly `RST_HOLD_CYCLES` cycles; in REL_IC, exactly `SEQ_GAP_CYCLES` cycles.
- If the abort condition and the terminal count occur on the same edge, the abort wins.
- If `pl_rst` is asserted mid-sequence, all outputs return to their reset values on the next edge.

## Configuration
- `PL_RESET_SEQ_LOCK_WDOG_EN` defined:
  - A 32-bit watchdog counts cycles spent in WAIT_LOCK and clears on leaving WAIT_LOCK.
  - On the edge the count reaches `LOCK_TIMEOUT_CYCLES`-1, `lock_timeout` is set to 1.
  - `lock_timeout` stays set until `pl_rst`, even if lock is later achieved. It does not affect the FSM.
- `PL_RESET_SEQ_LOCK_WDOG_EN` undefined: no watchdog logic is present and `lock_timeout` is a constant 0.

## Structure
- `pl_reset_seq_pkg` holds:
  - the `pl_rst_state_t` enum (3-bit, codes as listed above)
  - the `RUN_CNT_W=32` constant
  - the `SYNC_STAGES=2` constant
- `pl_sync_2ff` sub-module: a single-bit synchroniser with synchronous active-high clear, instantiated twice.

## Test plan
- Lock-up test: `RST_HOLD_CYCLES`=16, `SEQ_GAP_CYCLES`=4, `dcm_locked`=1 throughout, `pl_rst` first low at edge 0.
  - HOLD at edge 2.
  - `interconnect_aresetn` rises at edge 18.
  - `peripheral_aresetn` rises at edge 22; `run_cycles`=10 after edge 32.
- Lock loss: drop `dcm_locked` for 1 cycle while in RUN → 3 edges later `rst_state`=1, both resets asserted, `run_cycles`=0. The full sequence then replays.
- Aux request during HOLD: pulse `aux_reset_in` → return to WAIT_LOCK; the HOLD count restarts from 0 after `aux_s` falls.
- `pl_rst` asserted during REL_IC → next edge all outputs at reset values. Deasserting it replays the lock-up timing with the same edge offsets.
- Minimum parameters (1, 1) → HOLD and REL_IC each last exactly 1 cycle.
- With `PL_RESET_SEQ_LOCK_WDOG_EN` defined, `LOCK_TIMEOUT_CYCLES`=8 and `dcm_locked`=0:
  - `lock_timeout`=1 after 8 cycles in WAIT_LOCK.
  - It stays 1 after lock arrives and clears only on `pl_rst`.
- Same stimulus without the macro → `lock_timeout` stays 0.

Source files
------------

// File: rtl/pl_reset_seq_pkg.sv
// Shared types and constants for the staged PL reset sequencer.
package pl_reset_seq_pkg;

    typedef enum logic [2:0] {
        StReset    = 3'd0,
        StWaitLock = 3'd1,
        StHold     = 3'd2,
        StRelIc    = 3'd3,
        StRun      = 3'd4
    } pl_rst_state_t;

    localparam int unsigned RUN_CNT_W   = 32;
    localparam int unsigned SYNC_STAGES = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pl_sync_2ff.sv
// Single-bit multi-flop synchroniser with synchronous active-high clear.
module pl_sync_2ff
    import pl_reset_seq_pkg::*;
(
    input  logic clk_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pl_reset_seq.sv
// Staged PL reset sequencer: interconnect released before peripherals once lock is stable.
// Optional lock watchdog enabled by defining PL_RESET_SEQ_LOCK_WDOG_EN.
module pl_reset_seq
    import pl_reset_seq_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES     = 16,
    parameter int unsigned SEQ_GAP_CYCLES      = 4,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1024
) (
    input  logic                 pl_clk0,
    input  logic                 pl_rst,
    input  logic                 dcm_locked,
    input  logic                 aux_reset_in,
    output logic                 interconnect_aresetn,
    output logic                 peripheral_aresetn,
    output logic                 peripheral_reset,
    output logic [2:0]           rst_state,
    output logic [RUN_CNT_W-1:0] run_cycles,
    output logic                 lock_timeout
);

    localparam int unsigned CntW = $clog2(max_u(RST_HOLD_CYCLES, SEQ_GAP_CYCLES)) + 1;
    localparam logic [CntW-1:0] HoldLast = CntW'(RST_HOLD_CYCLES - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(SEQ_GAP_CYCLES - 1);

    logic locked_s, aux_s, abort;

    pl_sync_2ff u_sync_locked (
        .clk_i (pl_clk0),
        .clr_i (pl_rst),
        .d_i   (dcm_locked),
        .q_o   (locked_s)
    );

    pl_sync_2ff u_sync_aux (
        .clk_i (pl_clk0),
        .clr_i (pl_rst),
        .d_i   (aux_reset_in),
        .q_o   (aux_s)
    );

    pl_rst_state_t        state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [RUN_CNT_W-1:0] run_q, run_d;
    logic                 ic_aresetn_q, per_aresetn_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        abort   = !locked_s || aux_s;
        case (state_q)
            StReset: state_d = StWaitLock;
            StWaitLock: begin
                if (!abort) begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            end
            StHold: begin
                // Abort outranks the terminal count.
                if (abort) begin
                    state_d = StWaitLock;
                end else if (cnt_q == HoldLast) begin
                    state_d = StRelIc;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRelIc: begin
                if (abort) begin
                    state_d = StWaitLock;
                end else if (cnt_q == GapLast) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StWaitLock;
                end
            end
            default: state_d = StReset;
        endcase

        if (state_d != StRun) begin
            run_d = '0;
        end else if (state_q == StRun && run_q != '1) begin
            run_d = run_q + 1'b1;
        end else begin
            run_d = run_q;
        end
    end

    always_ff @(posedge pl_clk0) begin
        if (pl_rst) begin
            state_q       <= StReset;
            cnt_q         <= '0;
            run_q         <= '0;
            ic_aresetn_q  <= 1'b0;
            per_aresetn_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            ic_aresetn_q  <= (state_d == StRelIc) || (state_d == StRun);
            per_aresetn_q <= (state_d == StRun);
        end
    end

    assign interconnect_aresetn = ic_aresetn_q;
    assign peripheral_aresetn   = per_aresetn_q;
    assign peripheral_reset     = ~per_aresetn_q;
    assign rst_state            = state_q;
    assign run_cycles           = run_q;

`ifdef PL_RESET_SEQ_LOCK_WDOG_EN
    logic [31:0] wdog_q, wdog_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        wdog_d    = '0;
        timeout_d = timeout_q;
        if (state_q == StWaitLock) begin
            wdog_d = (wdog_q != '1) ? wdog_q + 1'b1 : wdog_q;
            if (wdog_q == 32'(LOCK_TIMEOUT_CYCLES - 1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge pl_clk0) begin
        if (pl_rst) begin
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

    assign lock_timeout = timeout_q;
`else
    // Watchdog absent; the parameter stays in the interface for build compatibility.
    assign lock_timeout = (LOCK_TIMEOUT_CYCLES == 0) & 1'b0;
`endif

endmodule
